bram_sdp_param: RTL and testbench

Parametrised simple-dual-port block RAM: one write port and one read port on a single clock, with configurable data width, depth and read latency. It has a selectable read-during-write collision mode and an optional post-reset clear sweep. A `rd_valid` strobe is aligned with read data. It is the storage primitive for the BRAM-backed priority-queue tree levels, replacing the fixed 8-bit x 256 RAM.

---
 rtl/bram_sdp_param.sv | 141 ++++++++++++++
 tb/tb_bram_sdp_param.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_param.sv
// Simple-dual-port block RAM: one write port, one read port, single clock.
// Selectable collision mode, optional output register and post-reset clear sweep.
module bram_sdp_param #(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       DEPTH          = 256,
  parameter int unsigned       WRITE_FIRST    = 1,
  parameter int unsigned       OUT_REG        = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_we;
  logic              accept;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              rd_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Traffic is also gated by rstn so nothing is accepted on a reset edge
  // even while the state register still reads READY.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: begin
        clr_we = rstn;
        if (clr_cnt == LAST_IDX) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: accept = rstn;
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign ready = (state == ST_READY);

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_ok       = accept && wr_en && wr_in_range;
  assign rd_ok       = accept && rd_en;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLEAR_VAL;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read-first falls out of the array holding its pre-edge value.
  always_comb begin
    rd_word = mem[rd_idx];
    if (!rd_in_range) begin
      rd_word = CLEAR_VAL;
    end else if ((WRITE_FIRST != 0) && wr_ok && (wr_addr == rd_addr)) begin
      rd_word = wr_data;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_valid;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        pipe_data  <= '0;
        pipe_valid <= 1'b0;
        rd_data    <= '0;
        rd_valid   <= 1'b0;
      end else begin
        pipe_valid <= rd_ok;
        if (rd_ok) begin
          pipe_data <= rd_word;
        end
        rd_valid <= pipe_valid;
        if (pipe_valid) begin
          rd_data <= pipe_data;
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk) begin
      if (!rstn) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) begin
          rd_data <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_param.sv
// Directed bench for bram_sdp_param: three instances cover clear sweep,
// write-first/read-first collisions, latency 1/2 streaming and out-of-range.
module tb_bram_sdp_param;

  logic       clk;
  logic       rstn     [3];
  logic       wr_en    [3];
  logic [7:0] wr_addr  [3];
  logic [7:0] wr_data  [3];
  logic       rd_en    [3];
  logic [7:0] rd_addr  [3];
  logic [7:0] rd_data  [3];
  logic       rd_valid [3];
  logic       ready    [3];

  int checks = 0;
  int errors = 0;

  // A: 16 deep, clear to A5, write-first, latency 1
  bram_sdp_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WRITE_FIRST(1), .OUT_REG(0),
                   .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hA5)) u_a (
    .clk(clk), .rstn(rstn[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .ready(ready[0]));

  // B: 256 deep, no clear, read-first, latency 2
  bram_sdp_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WRITE_FIRST(0), .OUT_REG(1),
                   .CLEAR_ON_RESET(0), .CLEAR_VAL(8'h00)) u_b (
    .clk(clk), .rstn(rstn[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .ready(ready[1]));

  // C: 200 deep, clear to 5A, write-first, latency 1
  bram_sdp_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WRITE_FIRST(1), .OUT_REG(0),
                   .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h5A)) u_c (
    .clk(clk), .rstn(rstn[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
    .ready(ready[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Steps until ready is seen; edges = 0 on timeout. Drops strobes once ready.
  task automatic wait_ready(input int d, input int limit, output int edges, output int vseen);
    edges = 0;
    vseen = 0;
    for (int e = 1; e <= limit; e++) begin
      tick();
      if (rd_valid[d] !== 1'b0) vseen++;
      if (ready[d] === 1'b1) begin
        edges    = e;
        wr_en[d] = 1'b0;
        rd_en[d] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int edges;
    int vseen;
    repeat (3) tick();
    checks++;
    if (ready[0] !== 1'b0 || rd_valid[0] !== 1'b0 || rd_data[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ready=%b rd_valid=%b rd_data=%h, expected 0 0 00",
               ready[0], rd_valid[0], rd_data[0]);
    end
    rstn[0]    = 1'b1;
    wr_en[0]   = 1'b1;
    wr_addr[0] = 8'd3;
    wr_data[0] = 8'h77;
    rd_en[0]   = 1'b1;
    rd_addr[0] = 8'd3;
    wait_ready(0, 40, edges, vseen);
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL clear_ready_edges: got %0d, expected 17", edges);
    end
    checks++;
    if (vseen != 0) begin
      errors++;
      $display("FAIL clear_no_valid: rd_valid seen %0d times, expected 0", vseen);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en[0]   = 1'b1;
      rd_addr[0] = 8'(i);
      tick();
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'hA5) begin
        errors++;
        $display("FAIL clear_read[%0d]: valid=%b data=%h, expected 1 a5", i, rd_valid[0], rd_data[0]);
      end
    end
    rd_en[0] = 1'b0;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b0 || rd_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL hold_after_read: valid=%b data=%h, expected 0 a5", rd_valid[0], rd_data[0]);
    end
  endtask

  task automatic test_collision_wf;
    wr_en[0] = 1'b1; wr_addr[0] = 8'd7; wr_data[0] = 8'h11;
    tick();
    wr_data[0] = 8'h22;
    rd_en[0]   = 1'b1; rd_addr[0] = 8'd7;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h22) begin
      errors++;
      $display("FAIL collision_wf: valid=%b data=%h, expected 1 22", rd_valid[0], rd_data[0]);
    end
    wr_addr[0] = 8'd8; wr_data[0] = 8'h99;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h22) begin
      errors++;
      $display("FAIL post_collision_wf: valid=%b data=%h, expected 1 22", rd_valid[0], rd_data[0]);
    end
    wr_en[0]   = 1'b0;
    rd_addr[0] = 8'd8;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h99) begin
      errors++;
      $display("FAIL write_then_read: valid=%b data=%h, expected 1 99", rd_valid[0], rd_data[0]);
    end
    rd_en[0] = 1'b0;
    tick();
  endtask

  task automatic test_mid_sweep;
    int edges;
    int v1;
    int v2;
    v1 = 0;
    rstn[0] = 1'b0;
    tick();
    rstn[0] = 1'b1;
    rd_en[0] = 1'b1; rd_addr[0] = 8'd7;
    repeat (6) begin
      tick();
      if (rd_valid[0] !== 1'b0) v1++;
    end
    rstn[0] = 1'b0;
    tick();
    if (rd_valid[0] !== 1'b0) v1++;
    rstn[0] = 1'b1;
    wait_ready(0, 40, edges, v2);
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL midsweep_ready_edges: got %0d, expected 17", edges);
    end
    checks++;
    if (v1 + v2 != 0) begin
      errors++;
      $display("FAIL midsweep_no_valid: rd_valid seen %0d times, expected 0", v1 + v2);
    end
    rd_en[0] = 1'b1; rd_addr[0] = 8'd7;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL sweep_restart: valid=%b data=%h, expected 1 a5", rd_valid[0], rd_data[0]);
    end
    rd_en[0] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    rstn[1] = 1'b1;
    tick();
    checks++;
    if (ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL ready_noclear: ready=%b, expected 1", ready[1]);
    end
    for (int i = 0; i < 256; i++) begin
      wr_en[1] = 1'b1; wr_addr[1] = 8'(i); wr_data[1] = 8'(i) ^ 8'h3C;
      tick();
    end
    wr_en[1] = 1'b0;
    for (int k = 0; k < 258; k++) begin
      rd_en[1]   = (k < 256);
      rd_addr[1] = 8'(k);
      tick();
      exp_v = (k >= 1 && k <= 256);
      checks++;
      if (rd_valid[1] !== exp_v || (exp_v && rd_data[1] !== (8'(k - 1) ^ 8'h3C))) begin
        errors++;
        $display("FAIL b2b_lat2[%0d]: valid=%b data=%h, expected valid %b data %h",
                 k, rd_valid[1], rd_data[1], exp_v, 8'(k - 1) ^ 8'h3C);
      end
    end
  endtask

  task automatic test_collision_rf;
    wr_en[1] = 1'b1; wr_addr[1] = 8'd7; wr_data[1] = 8'h11;
    tick();
    wr_data[1] = 8'h22;
    rd_en[1]   = 1'b1; rd_addr[1] = 8'd7;
    tick();
    wr_en[1] = 1'b0; rd_en[1] = 1'b0;
    checks++;
    if (rd_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat2_gap: valid=%b, expected 0", rd_valid[1]);
    end
    tick();
    checks++;
    if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'h11) begin
      errors++;
      $display("FAIL collision_rf: valid=%b data=%h, expected 1 11", rd_valid[1], rd_data[1]);
    end
    rd_en[1] = 1'b1;
    tick();
    rd_en[1] = 1'b0;
    tick();
    checks++;
    if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'h22) begin
      errors++;
      $display("FAIL post_collision_rf: valid=%b data=%h, expected 1 22", rd_valid[1], rd_data[1]);
    end
    tick();
    checks++;
    if (rd_valid[1] !== 1'b0 || rd_data[1] !== 8'h22) begin
      errors++;
      $display("FAIL hold_lat2: valid=%b data=%h, expected 0 22", rd_valid[1], rd_data[1]);
    end
  endtask

  task automatic test_pipeline_flush;
    rd_en[1] = 1'b1; rd_addr[1] = 8'd5;
    tick();
    rd_en[1] = 1'b0;
    rstn[1]  = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++;
      if (rd_valid[1] !== 1'b0 || rd_data[1] !== 8'h00) begin
        errors++;
        $display("FAIL flush[%0d]: valid=%b data=%h, expected 0 00", j, rd_valid[1], rd_data[1]);
      end
    end
    rstn[1] = 1'b1;
    tick();
    checks++;
    if (rd_valid[1] !== 1'b0 || ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL flush_release: valid=%b ready=%b, expected 0 1", rd_valid[1], ready[1]);
    end
    rd_en[1] = 1'b1; rd_addr[1] = 8'd5;
    tick();
    rd_en[1] = 1'b0;
    tick();
    checks++;
    if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'h39) begin
      errors++;
      $display("FAIL retain_over_reset: valid=%b data=%h, expected 1 39", rd_valid[1], rd_data[1]);
    end
  endtask

  task automatic test_out_of_range;
    int edges;
    int vseen;
    rstn[2] = 1'b1;
    wait_ready(2, 260, edges, vseen);
    checks++;
    if (edges != 201) begin
      errors++;
      $display("FAIL c_ready_edges: got %0d, expected 201", edges);
    end
    for (int i = 0; i < 200; i++) begin
      wr_en[2] = 1'b1; wr_addr[2] = 8'(i); wr_data[2] = 8'(i) ^ 8'h3C;
      tick();
    end
    wr_en[2] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      rd_en[2] = 1'b1; rd_addr[2] = 8'(k);
      tick();
      checks++;
      if (rd_valid[2] !== 1'b1 || rd_data[2] !== (8'(k) ^ 8'h3C)) begin
        errors++;
        $display("FAIL b2b_lat1[%0d]: valid=%b data=%h, expected 1 %h",
                 k, rd_valid[2], rd_data[2], 8'(k) ^ 8'h3C);
      end
    end
    rd_en[2] = 1'b0;
    wr_en[2] = 1'b1; wr_addr[2] = 8'd210; wr_data[2] = 8'hFF;
    tick();
    wr_en[2] = 1'b0;
    rd_en[2] = 1'b1; rd_addr[2] = 8'd210;
    tick();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== 8'h5A) begin
      errors++;
      $display("FAIL oor_read: valid=%b data=%h, expected 1 5a", rd_valid[2], rd_data[2]);
    end
    rd_addr[2] = 8'd199;
    tick();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== 8'hFB) begin
      errors++;
      $display("FAIL last_entry: valid=%b data=%h, expected 1 fb", rd_valid[2], rd_data[2]);
    end
    wr_en[2] = 1'b1; wr_addr[2] = 8'd210; wr_data[2] = 8'hFF;
    rd_addr[2] = 8'd210;
    tick();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== 8'h5A) begin
      errors++;
      $display("FAIL oor_collision: valid=%b data=%h, expected 1 5a", rd_valid[2], rd_data[2]);
    end
    wr_en[2] = 1'b0; rd_en[2] = 1'b0;
    tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn[d]    = 1'b0;
      wr_en[d]   = 1'b0;
      wr_addr[d] = 8'h00;
      wr_data[d] = 8'h00;
      rd_en[d]   = 1'b0;
      rd_addr[d] = 8'h00;
    end
    test_reset();
    test_collision_wf();
    test_mid_sweep();
    test_back_to_back();
    test_collision_rf();
    test_pipeline_flush();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
